// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and the
// helper that sizes the single down-counter.
package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STRETCH = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   // Bits needed to hold max(a, b) - 1; never less than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a single-cycle request on pulse_in into a level of
// STRETCH_CYCLES clocks on level_out, followed by HOLDOFF_CYCLES of dead time
// in which requests are rejected and counted.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   pulse_in    request pulse; every high cycle counts as one request
//   clear_drop  synchronous clear of drop_count, wins over a same-cycle drop
//   level_out   stretched level
//   busy        high whenever the FSM is not in IDLE
//   done_pulse  one-cycle strobe on the final level_out cycle of a stretch
//   drop_count  saturating count of rejected requests
//
// state   | meaning
// IDLE    | waiting for a request
// STRETCH | level_out high, counter holds remaining stretch cycles - 1
// HOLDOFF | dead time, counter holds remaining holdoff cycles - 1
module pulse_stretcher
   import pulse_pkg::*;
#(
   parameter int STRETCH_CYCLES = 4,
   parameter int HOLDOFF_CYCLES = 2,
   parameter int RETRIGGER      = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pulse_in,
   input  logic       clear_drop,
   output logic       level_out,
   output logic       busy,
   output logic       done_pulse,
   output logic [7:0] drop_count
);

   localparam int CW = cnt_width(STRETCH_CYCLES, HOLDOFF_CYCLES);
   localparam logic [CW-1:0] S_LOAD = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] H_LOAD = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            reject;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            if (pulse_in) begin
               state_nxt = STRETCH;
               cnt_nxt   = S_LOAD;
            end
         end
         STRETCH: begin
            if (pulse_in && (RETRIGGER != 0)) begin
               cnt_nxt = S_LOAD;
            end else begin
               reject = pulse_in;
               if (cnt == '0) begin
                  if (HOLDOFF_CYCLES > 0) begin
                     state_nxt = HOLDOFF;
                     cnt_nxt   = H_LOAD;
                  end else begin
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                  end
               end else begin
                  cnt_nxt = cnt - CW'(1);
               end
            end
         end
         HOLDOFF: begin
            reject = pulse_in;
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state values, so done_pulse lines
   // up with the last cycle in which the counter sits at zero in STRETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         level_out  <= 1'b0;
         busy       <= 1'b0;
         done_pulse <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         level_out  <= (state_nxt == STRETCH);
         busy       <= (state_nxt != IDLE);
         done_pulse <= (state_nxt == STRETCH) && (cnt_nxt == '0);
         if (clear_drop) begin
            drop_count <= 8'd0;
         end else if (reject && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule
